// File: rtl/logic_pipe_pkg.sv
// Shared types and helpers for the logic pipeline unit.
// Contents: op_e operation encoding, bit-level op evaluation helper.
// No ports; imported by logic_pipe_alu and logic_pipe_unit.
package logic_pipe_pkg;

  localparam int OP_W = 3;

  // Operation select carried alongside each beat.
  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  // Evaluates one operation on a single bit pair. Working per bit keeps the
  // helper independent of operand width: callers loop it across any WIDTH.
  // b is ignored by the unary ops (NOT_A, PASS_A).
  function automatic logic apply_op(op_e op, logic a, logic b);
    logic r;
    r = a;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XOR:    r = a ^ b;
      OP_XNOR:   r = ~(a ^ b);
      OP_NOT_A:  r = ~a;
      OP_PASS_A: r = a;
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_alu.sv
// Purpose: purely combinational WIDTH-bit bitwise operation with result flags.
// Latency: zero cycles (combinational).
// Backpressure: none; evaluated every cycle from whatever sits in stage 1.
// Ports: op_i (3-bit op_e code), a_i/b_i operands, y_o result,
//        zero_o (y_o all zeros), ones_o (y_o all ones).
module logic_pipe_alu #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o,
  output logic             ones_o
);
  import logic_pipe_pkg::*;

  op_e op;

  assign op = op_e'(op_i);

  always_comb begin
    y_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y_o[i] = apply_op(op, a_i[i], b_i[i]);
    end
  end

  assign zero_o = ~|y_o;
  assign ones_o = &y_o;

endmodule

// File: rtl/logic_pipe_unit.sv
// Purpose: two-stage pipelined bitwise op unit (8 ops) with zero/ones flags and saturating completion count.
// Latency: 2 cycles from input handshake to out_valid when not stalled; one beat per cycle throughput.
// Backpressure: valid/ready both sides; holds up to 2 beats, in_ready falls combinationally with out_ready.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_a, in_b operands, in_op op_e code
//   out_valid/out_ready output handshake; out_y result, out_op producing op,
//                       out_zero / out_ones result flags
//   op_count            output handshakes completed, saturating at all ones
module logic_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] op_count
);
  import logic_pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1: captured operands.
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  // Stage 2: computed result presented to the consumer.
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic [2:0]       s2_op_q, s2_op_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_ones_q, s2_ones_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Advance enables: a stage may load when it is empty or its contents move on
  // this edge. The chain makes in_ready combinational from out_ready so that a
  // full pipe still streams at one beat per cycle.
  logic s2_adv;
  logic s1_adv;
  logic out_hs;

  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_ones;

  logic_pipe_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i  (s1_op_q),
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .y_o   (alu_y),
    .zero_o(alu_zero),
    .ones_o(alu_ones)
  );

  assign s2_adv = !s2_vld_q || out_ready;
  assign s1_adv = !s1_vld_q || s2_adv;
  assign out_hs = s2_vld_q && out_ready;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_op_d   = s1_op_q;
    s2_vld_d  = s2_vld_q;
    s2_y_d    = s2_y_q;
    s2_op_d   = s2_op_q;
    s2_zero_d = s2_zero_q;
    s2_ones_d = s2_ones_q;
    cnt_d     = cnt_q;

    // Stage 1 takes a beat only on a handshake; otherwise it drains to a
    // bubble and leaves the stale operands in place.
    if (s1_adv) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_a_d  = in_a;
        s1_b_d  = in_b;
        s1_op_d = in_op;
      end
    end

    // Stage 2 loads whatever stage 1 holds, including a bubble. Payload is
    // only overwritten by a real beat so held outputs never glitch.
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_y_d    = alu_y;
        s2_op_d   = s1_op_q;
        s2_zero_d = alu_zero;
        s2_ones_d = alu_ones;
      end
    end

    if (out_hs && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_op_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_y_q    <= '0;
      s2_op_q   <= '0;
      s2_zero_q <= 1'b0;
      s2_ones_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_op_q   <= s1_op_d;
      s2_vld_q  <= s2_vld_d;
      s2_y_q    <= s2_y_d;
      s2_op_q   <= s2_op_d;
      s2_zero_q <= s2_zero_d;
      s2_ones_q <= s2_ones_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_vld_q;
  assign out_y     = s2_y_q;
  assign out_op    = s2_op_q;
  assign out_zero  = s2_zero_q;
  assign out_ones  = s2_ones_q;
  assign op_count  = cnt_q;

endmodule
